// File: rtl/rv_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per clock; divide-by-zero and signed overflow complete without iterating.
//
// state | meaning
// IDLE  | ready to accept a new operation
// CALC  | one restoring shift/subtract step per clock
// DONE  | result valid for exactly one cycle
module rv_divider #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_res
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count;
    logic            is_rem, neg_q, neg_r;
    logic [XLEN-1:0] divisor, rem, quo;

    logic            accept, is_signed, a_neg, b_neg, div_zero, ovf, special, last;
    logic [XLEN-1:0] abs_a, abs_b, special_res;
    logic [XLEN:0]   rem_sh, trial;
    logic [XLEN-1:0] rem_nxt, quo_nxt, final_q, final_r;

    assign o_ready = (state == IDLE);
    assign o_busy  = (state != IDLE);
    assign o_valid = (state == DONE);

    // A flush in the same cycle as i_valid wins, so nothing is accepted.
    assign accept    = i_valid && (state == IDLE) && !i_flush;
    assign is_signed = ~i_op[0];
    assign a_neg     = is_signed & i_a[XLEN-1];
    assign b_neg     = is_signed & i_b[XLEN-1];
    assign abs_a     = a_neg ? (~i_a + 1'b1) : i_a;
    assign abs_b     = b_neg ? (~i_b + 1'b1) : i_b;
    assign div_zero  = (i_b == '0);
    assign ovf       = is_signed && (i_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_b == '1);
    assign special   = div_zero || ovf;

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = i_op[1] ? i_a : '1;
        else
            special_res = i_op[1] ? '0 : i_a;
    end

    // Remainder gets one extra bit so the trial subtraction's sign is the borrow.
    assign rem_sh = {rem, quo[XLEN-1]};
    assign trial  = rem_sh - {1'b0, divisor};
    assign last   = (count == CW'(XLEN-1));

    always_comb begin
        rem_nxt = rem_sh[XLEN-1:0];
        quo_nxt = {quo[XLEN-2:0], 1'b0};
        if (!trial[XLEN]) begin
            rem_nxt = trial[XLEN-1:0];
            quo_nxt = {quo[XLEN-2:0], 1'b1};
        end
    end

    assign final_q = neg_q ? (~quo_nxt + 1'b1) : quo_nxt;
    assign final_r = neg_r ? (~rem_nxt + 1'b1) : rem_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = special ? DONE : CALC;
            CALC: if (last)   state_nxt = DONE;
            DONE:             state_nxt = IDLE;
            default:          state_nxt = IDLE;
        endcase
        if (i_flush)
            state_nxt = IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count   <= '0;
            is_rem  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            divisor <= '0;
            rem     <= '0;
            quo     <= '0;
            o_res   <= '0;
        end else if (accept) begin
            count   <= '0;
            is_rem  <= i_op[1];
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            divisor <= abs_b;
            rem     <= '0;
            quo     <= abs_a;
            if (special)
                o_res <= special_res;
        end else if (state == CALC && !i_flush) begin
            rem   <= rem_nxt;
            quo   <= quo_nxt;
            count <= count + 1'b1;
            if (last)
                o_res <= is_rem ? final_r : final_q;
        end
    end

endmodule

// File: tb/tb_rv_divider.sv
// Self-checking bench for rv_divider: directed corner cases, flush/reset/back-to-back
// behaviour and a randomized sweep against an arithmetic reference model.
module tb_rv_divider;

    logic        i_clk = 1'b0;
    logic        i_rst, i_flush, i_valid;
    logic [1:0]  i_op;
    logic [31:0] i_a, i_b;
    logic        o_ready, o_busy, o_valid;
    logic [31:0] o_res;

    int vectors = 0;
    int errors  = 0;

    rv_divider #(.XLEN(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid),
        .o_ready(o_ready), .i_op(i_op), .i_a(i_a), .i_b(i_b),
        .o_busy(o_busy), .o_valid(o_valid), .o_res(o_res)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V M-extension semantics via 64-bit signed arithmetic.
    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ua, ub, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            2'b00: if (b == 0) r = -1; else r = sa / sb;
            2'b01: if (b == 0) r = -1; else r = ua / ub;
            2'b10: if (b == 0) r = sa; else r = sa % sb;
            default: if (b == 0) r = ua; else r = ua % ub;
        endcase
        return r[31:0];
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Issues one op and waits for its result. lat = edges after the accept edge
    // at which o_valid was seen (0 = cycle right after the accept edge), -1 on timeout.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res);
        @(negedge i_clk);
        check("ready_before_issue", {31'b0, o_ready}, 32'd1);
        i_valid = 1'b1; i_op = op; i_a = a; i_b = b;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_op = 2'($urandom); i_a = $urandom; i_b = $urandom;
        lat = -1;
        res = 'x;
        for (int k = 0; k < 40; k++) begin
            if (o_valid) begin
                lat = k;
                res = o_res;
                break;
            end
            @(posedge i_clk); #1;
        end
        if (lat >= 0) begin
            @(posedge i_clk); #1;
            check("valid_single_pulse", {31'b0, o_valid}, 32'd0);
            check("ready_after_done", {31'b0, o_ready}, 32'd1);
        end
    endtask

    task automatic op_and_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b);
        int lat;
        logic [31:0] res;
        run_op(op, a, b, lat, res);
        check({tag, "_res"}, res, ref_model(op, a, b));
        if (is_special(op, a, b))
            check({tag, "_lat_special"}, {31'b0, (lat == 0 || lat == 1)}, 32'd1);
        else
            check({tag, "_lat"}, lat, 32'd32);
    endtask

    initial begin
        int lat, pulses, quiet_valid;
        logic [31:0] res;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_op = '0; i_a = '0; i_b = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        check("rst_ready", {31'b0, o_ready}, 32'd1);
        check("rst_busy",  {31'b0, o_busy},  32'd0);
        check("rst_valid", {31'b0, o_valid}, 32'd0);
        check("rst_res",   o_res,            32'd0);

        // Directed cases, with expected values written out by hand.
        run_op(2'b01, 32'd100, 32'd7, lat, res);
        check("divu_100_7", res, 32'd14);
        check("divu_100_7_lat", lat, 32'd32);
        run_op(2'b11, 32'd100, 32'd7, lat, res);
        check("remu_100_7", res, 32'd2);
        run_op(2'b00, -32'sd7, 32'd2, lat, res);
        check("div_m7_2", res, 32'hFFFF_FFFD);
        run_op(2'b10, -32'sd7, 32'd2, lat, res);
        check("rem_m7_2", res, 32'hFFFF_FFFF);
        run_op(2'b10, 32'd7, -32'sd2, lat, res);
        check("rem_7_m2", res, 32'd1);
        run_op(2'b01, 32'd5, 32'd0, lat, res);
        check("divu_5_0", res, 32'hFFFF_FFFF);
        check("divu_5_0_lat", {31'b0, (lat == 0 || lat == 1)}, 32'd1);
        run_op(2'b11, 32'd5, 32'd0, lat, res);
        check("remu_5_0", res, 32'd5);
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
        check("div_ovf", res, 32'h8000_0000);
        check("div_ovf_lat", {31'b0, (lat == 0 || lat == 1)}, 32'd1);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
        check("rem_ovf", res, 32'd0);

        // Flush at count=10: o_res must keep the previous result (REMU 100/7 = 2).
        run_op(2'b11, 32'd100, 32'd7, lat, res);
        check("pre_flush_res", res, 32'd2);
        @(negedge i_clk);
        i_valid = 1'b1; i_op = 2'b01; i_a = 32'd100; i_b = 32'd7;
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (10) @(negedge i_clk);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        check("flush_busy",  {31'b0, o_busy},  32'd0);
        check("flush_ready", {31'b0, o_ready}, 32'd1);
        check("flush_res",   o_res,            32'd2);
        quiet_valid = 0;
        repeat (40) begin
            @(negedge i_clk);
            if (o_valid) quiet_valid++;
        end
        check("flush_no_valid", quiet_valid, 32'd0);
        run_op(2'b01, 32'd9, 32'd3, lat, res);
        check("after_flush_divu_9_3", res, 32'd3);

        // Flush together with i_valid in IDLE: not accepted.
        @(negedge i_clk);
        i_valid = 1'b1; i_flush = 1'b1; i_op = 2'b01; i_a = 32'd50; i_b = 32'd5;
        @(negedge i_clk);
        i_valid = 1'b0; i_flush = 1'b0;
        check("flush_blocks_accept", {31'b0, o_busy}, 32'd0);

        // Reset mid-calculation.
        @(negedge i_clk);
        i_valid = 1'b1; i_op = 2'b01; i_a = 32'd1000; i_b = 32'd3;
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (5) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("midrst_res",   o_res,            32'd0);
        check("midrst_busy",  {31'b0, o_busy},  32'd0);
        check("midrst_ready", {31'b0, o_ready}, 32'd1);

        // i_valid held high across two ops: exactly two result pulses.
        pulses = 0;
        @(negedge i_clk);
        i_valid = 1'b1; i_op = 2'b01; i_a = 32'd100; i_b = 32'd7;
        for (int c = 0; c < 200; c++) begin
            @(negedge i_clk);
            if (o_valid) begin
                pulses++;
                check("b2b_res", o_res, 32'd14);
                if (pulses == 2) i_valid = 1'b0;
            end
        end
        i_valid = 1'b0;
        check("b2b_pulses", pulses, 32'd2);

        // Random sweep, biased toward small divisors, zero, -1 and the overflow dividend.
        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom_range(1, 15);
                3: rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            op_and_check($sformatf("rand%0d", n), rop, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
